imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the CORG `instruction_memory` (asynchronous read: 16-bit `pc` in, 16-bit `instruction` out) and the decode stage. Owns the program counter, drives the memory address every cycle it fetches, and buffers fetched words in a small FIFO with a valid/ready handshake toward decode. Handles redirects (branch/jump) by flushing the FIFO and restarting fetch at the new address.

---
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the async instruction
// memory and queues fetched words with their PCs in a small FIFO toward decode.
module imem_fetch_ctrl #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic [PC_W-1:0]           imem_pc,
    input  logic [INSTR_W-1:0]        imem_instr,
    input  logic                      redir_valid,
    input  logic [PC_W-1:0]           redir_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [PC_W-1:0]           out_pc,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      w_redir_tgt;
    logic [INSTR_W-1:0]   r_instr_mem [DEPTH];
    logic [PC_W-1:0]      r_pc_mem    [DEPTH];
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW:0]          r_count;
    logic                 w_push;
    logic                 w_pop;

    // Redirect targets beyond the memory depth fold back into range.
    assign w_redir_tgt = PC_W'(32'(redir_pc) % MEM_WORDS);
    assign w_pc_inc    = (r_fetch_pc == PC_W'(MEM_WORDS - 1)) ? '0 : r_fetch_pc + PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_push      = 1'b0;

        w_pop = (r_count != '0) && out_ready;

        if (redir_valid) begin
            w_state_nxt = REDIR;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = en ? FETCH : IDLE;
                FETCH:   w_state_nxt = en ? FETCH : IDLE;
                REDIR:   w_state_nxt = en ? FETCH : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end

        // A full FIFO still accepts a fetch when its head leaves this cycle.
        if (r_state == FETCH && !redir_valid && ((r_count < CNT_FULL) || w_pop)) begin
            w_push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= PC_W'(RESET_PC);
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redir_valid) begin
                r_fetch_pc <= w_redir_tgt;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= w_pc_inc;
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_instr;
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign imem_pc    = r_fetch_pc;
    assign fifo_count = r_count;
    assign out_valid  = (r_count != '0);
    assign out_instr  = out_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign out_pc     = out_valid ? r_pc_mem[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl against a queue-based fetch model.
module tb_imem_fetch_ctrl;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned DEPTH     = 2;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [1:0]  fifo_count;

    imem_fetch_ctrl #(
        .PC_W      (16),
        .INSTR_W   (16),
        .MEM_WORDS (MEM_WORDS),
        .DEPTH     (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word[i] = i + 0x1000, read combinationally.
    assign imem_instr = imem_pc + 16'h1000;

    typedef struct {
        logic [15:0] pc;
        int          cnt;
        logic        valid;
        logic [15:0] hpc;
        logic [15:0] hinstr;
    } status_t;

    status_t     st_q[$];
    logic [15:0] del_q[$];

    logic [15:0] m_q[$];
    logic [15:0] m_pc;
    bit          m_fetching;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] wrap_pc(input logic [31:0] v);
        return 16'(v % MEM_WORDS);
    endfunction

    // One clock cycle of stimulus; the model predicts what the DUT shows
    // this cycle and then advances across the closing edge.
    task automatic cycle(input bit e, input bit r, input bit rv, input logic [15:0] rp);
        status_t s;
        int      sz;
        bit      pop;
        bit      fetch;
        @(posedge clk);
        #1;
        en          = e;
        out_ready   = r;
        redir_valid = rv;
        redir_pc    = rp;

        sz       = m_q.size();
        s.pc     = m_pc;
        s.cnt    = sz;
        s.valid  = (sz > 0);
        s.hpc    = (sz > 0) ? m_q[0] : 16'h0;
        s.hinstr = (sz > 0) ? m_q[0] + 16'h1000 : 16'h0;
        st_q.push_back(s);

        pop   = (sz > 0) && r;
        fetch = m_fetching && !rv && ((sz < int'(DEPTH)) || pop);
        if (pop) del_q.push_back(m_q[0]);

        if (rv) begin
            m_q.delete();
            m_pc = wrap_pc(32'(rp));
        end else begin
            if (pop) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back(m_pc);
                m_pc = wrap_pc(32'(m_pc) + 1);
            end
        end
        m_fetching = e && !rv;
    endtask

    task automatic model_reset();
        st_q.delete();
        del_q.delete();
        m_q.delete();
        m_pc       = RESET_PC;
        m_fetching = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_pc"},   32'(imem_pc),    32'(RESET_PC));
        chk({tag, "_out_valid"}, 32'(out_valid),  32'd0);
        chk({tag, "_out_instr"}, 32'(out_instr),  32'd0);
        chk({tag, "_out_pc"},    32'(out_pc),     32'd0);
        chk({tag, "_count"},     32'(fifo_count), 32'd0);
    endtask

    // Monitor: compares every cycle's visible state and each delivered word.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (rst_n && st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("imem_pc",    32'(imem_pc),    32'(s.pc));
                chk("fifo_count", 32'(fifo_count), 32'(s.cnt));
                chk("out_valid",  32'(out_valid),  32'(s.valid));
                chk("out_pc",     32'(out_pc),     32'(s.hpc));
                chk("out_instr",  32'(out_instr),  32'(s.hinstr));
                if (out_valid && out_ready) begin
                    chk("deliv_expected", 32'(del_q.size() != 0), 32'd1);
                    if (del_q.size() != 0) chk("deliv_pc", 32'(out_pc), 32'(del_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        out_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming, then backpressure with saturation and in-order release.
        repeat (10) cycle(1, 1, 0, 16'h0);
        repeat (5)  cycle(1, 0, 0, 16'h0);
        repeat (6)  cycle(1, 1, 0, 16'h0);

        // Redirect with a full FIFO.
        repeat (3)  cycle(1, 0, 0, 16'h0);
        cycle(1, 0, 1, 16'h0040);
        repeat (6)  cycle(1, 1, 0, 16'h0);

        // Wrap past MEM_WORDS-1 and an out-of-range redirect target.
        cycle(1, 1, 1, 16'h00FE);
        repeat (6)  cycle(1, 1, 0, 16'h0);
        cycle(1, 1, 1, 16'h0105);
        repeat (4)  cycle(1, 1, 0, 16'h0);

        // Drop enable with the FIFO full, drain, resume.
        repeat (3)  cycle(1, 0, 0, 16'h0);
        repeat (2)  cycle(0, 0, 0, 16'h0);
        repeat (4)  cycle(0, 1, 0, 16'h0);
        cycle(0, 1, 1, 16'h0033);
        repeat (2)  cycle(0, 1, 0, 16'h0);
        repeat (5)  cycle(1, 1, 0, 16'h0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, 16'($urandom));
        end

        // Asynchronous reset between edges while the FIFO is busy.
        repeat (3) cycle(1, 0, 0, 16'h0);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        en          = 1'b0;
        out_ready   = 1'b0;
        redir_valid = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) cycle(1, 1, 0, 16'h0);

        @(negedge clk);
        #1;
        chk("status_drained", 32'(st_q.size()),  32'd0);
        chk("deliv_drained",  32'(del_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
